// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - pipelined signed/unsigned Vedic multiplier with valid/ready handshake

// Unsigned Urdhva-Tiryagbhyam multiplier. Recursively splits into four
// half-width partial products down to 2x2 leaves.
module vedic_umul #(
    parameter int N = 4
) (
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic [2*N-1:0] o_p
);

    if (N == 2) begin : g_leaf
        logic w_t;
        logic w_u;
        logic w_hh;
        logic w_c1;
        assign w_t  = i_a[1] & i_b[0];
        assign w_u  = i_a[0] & i_b[1];
        assign w_hh = i_a[1] & i_b[1];
        assign w_c1 = w_t & w_u;
        // Vertical bit 0, crosswise sum at bit 1, vertical high pair plus carry.
        assign o_p  = {w_hh & w_c1, w_hh ^ w_c1, w_t ^ w_u, i_a[0] & i_b[0]};
    end else begin : g_tree
        localparam int H = N / 2;
        logic [N-1:0] w_ll;
        logic [N-1:0] w_lh;
        logic [N-1:0] w_hl;
        logic [N-1:0] w_hh;

        vedic_umul #(.N(H)) u_ll (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_ll));
        vedic_umul #(.N(H)) u_lh (.i_a(i_a[H-1:0]), .i_b(i_b[N-1:H]), .o_p(w_lh));
        vedic_umul #(.N(H)) u_hl (.i_a(i_a[N-1:H]), .i_b(i_b[H-1:0]), .o_p(w_hl));
        vedic_umul #(.N(H)) u_hh (.i_a(i_a[N-1:H]), .i_b(i_b[N-1:H]), .o_p(w_hh));

        // High and low vertical products concatenate; crosswise terms land at offset H.
        assign o_p = {w_hh, w_ll}
                   + {{H{1'b0}}, w_lh, {H{1'b0}}}
                   + {{H{1'b0}}, w_hl, {H{1'b0}}};
    end

endmodule

module vedic_mult_pipe #(
    parameter int W      = 32,
    parameter int STAGES = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           is_signed,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] Prod,
    output logic           overflow,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]   w_mag_a;
    logic [W-1:0]   w_mag_b;
    logic           w_neg;
    logic [2*W-1:0] w_uprod;
    logic [2*W-1:0] w_prod;
    logic           w_ovf;
    logic           w_advance;

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] r_ovf;
    logic [2*W-1:0]    r_prod [STAGES];

    // Magnitudes: -(-2^(W-1)) wraps back to 2^(W-1), which is the correct
    // unsigned magnitude, so the extreme negative operand needs no special case.
    assign w_mag_a = (is_signed && A[W-1]) ? -A : A;
    assign w_mag_b = (is_signed && B[W-1]) ? -B : B;
    assign w_neg   = is_signed & (A[W-1] ^ B[W-1]);

    vedic_umul #(.N(W)) u_core (.i_a(w_mag_a), .i_b(w_mag_b), .o_p(w_uprod));

    assign w_prod = w_neg ? -w_uprod : w_uprod;

    // Signed result fits in W bits only when the top W+1 bits are a pure sign extension.
    assign w_ovf = is_signed ? !((&w_prod[2*W-1:W-1]) || !(|w_prod[2*W-1:W-1]))
                             : (|w_prod[2*W-1:W]);

    // The whole pipe moves together; it may advance whenever the output slot frees.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Stage registers: valid bits always shift on advance, data only follows a valid upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_ovf <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_prod[s] <= '0;
            end
        end else if (w_advance) begin
            r_vld[0] <= in_valid;
            if (in_valid) begin
                r_prod[0] <= w_prod;
                r_ovf[0]  <= w_ovf;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_prod[s] <= r_prod[s-1];
                    r_ovf[s]  <= r_ovf[s-1];
                end
            end
        end
    end

    assign out_valid = r_vld[STAGES-1];
    assign Prod      = r_prod[STAGES-1];
    assign overflow  = r_ovf[STAGES-1];

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb/tb_vedic_mult_pipe.sv - self-checking bench for vedic_mult_pipe (W=32, STAGES=3)
module tb_vedic_mult_pipe;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [63:0] prod;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [63:0] prod;
        logic        ovf;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        is_signed;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] Prod;
    logic        overflow;
    logic        out_valid;
    logic        out_ready;

    logic [63:0] drv_prod;
    logic        drv_ovf;
    logic        lat_en;
    int          cyc;
    int          n_pass;
    int          n_total;
    int          n_out;
    int          rdy_err;
    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        tv[17];

    vedic_mult_pipe #(.W(32), .STAGES(3)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .is_signed(is_signed),
        .in_valid(in_valid), .in_ready(in_ready), .Prod(Prod),
        .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] p, input logic o);
        A         = a;
        B         = b;
        is_signed = s;
        in_valid  = 1'b1;
        drv_prod  = p;
        drv_ovf   = o;
    endtask

    // Scoreboard: output side first, then record the pair accepted at the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else begin
            if (in_ready !== (!out_valid || out_ready)) rdy_err++;
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", {63'b0, out_valid}, 64'd0);
                end else if (out_ready) begin
                    mon_e = sbq.pop_front();
                    n_out++;
                    chk("prod", Prod, mon_e.prod);
                    chk("ovf", {63'b0, overflow}, {63'b0, mon_e.ovf});
                    if (lat_en) chk("latency", 64'(cyc - mon_e.acc), 64'd3);
                end else begin
                    chk("stall_prod", Prod, sbq[0].prod);
                end
            end
            if (in_valid && in_ready) sbq.push_back('{drv_prod, drv_ovf, cyc});
        end
    end

    initial begin
        int   k;
        int   base;
        int   bad;
        logic acc;
        logic saw_nr;
        logic [7:0] hist;

        tv[0]  = '{32'h00000444, 32'h00000444, 1'b0, 64'h0000000000123210, 1'b0};
        tv[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1};
        tv[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 1'b0};
        tv[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1};
        tv[4]  = '{32'hFFFFFFFE, 32'h00000003, 1'b1, 64'hFFFFFFFFFFFFFFFA, 1'b0};
        tv[5]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 1'b1};
        tv[6]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000, 1'b1};
        tv[7]  = '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001, 1'b0};
        tv[8]  = '{32'hFFFFFFFF, 32'h00000005, 1'b1, 64'hFFFFFFFFFFFFFFFB, 1'b0};
        tv[9]  = '{32'h7FFFFFFF, 32'h00000002, 1'b1, 64'h00000000FFFFFFFE, 1'b1};
        tv[10] = '{32'h3FFFFFFF, 32'h00000002, 1'b1, 64'h000000007FFFFFFE, 1'b0};
        tv[11] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, 1'b0};
        tv[12] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC000000080000000, 1'b1};
        tv[13] = '{32'h0000ABCD, 32'h00001234, 1'b0, 64'h000000000C374FA4, 1'b0};
        tv[14] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF, 1'b0};
        tv[15] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000, 1'b0};
        tv[16] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001, 1'b1};

        cyc = 0; n_pass = 0; n_total = 0; n_out = 0; rdy_err = 0;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0;
        out_ready = 1'b1; lat_en = 1'b1; drv_prod = '0; drv_ovf = 1'b0;

        // Reset state.
        repeat (2) tick();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_prod", Prod, 64'd0);
        chk("rst_ovf", {63'b0, overflow}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Back-to-back table, first pair presented in the first cycle out of reset.
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(tv[i].a, tv[i].b, tv[i].sgn, tv[i].prod, tv[i].ovf);
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        chk("table_count", 64'(n_out), 64'd17);

        // Backpressure: out_ready low for cycles 4..8.
        lat_en = 1'b0;
        base = n_out;
        k = 1;
        saw_nr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            out_ready = !(i >= 4 && i <= 8);
            if (k <= 6) drive(32'(k), 32'(k), 1'b0, 64'(k * k), 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            if (!in_ready) saw_nr = 1'b1;
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        chk("bp_all_accepted", 64'(k), 64'd7);
        chk("bp_saw_not_ready", {63'b0, saw_nr}, 64'd1);
        chk("bp_count", 64'(n_out - base), 64'd6);

        // Bubble pattern 1,0,1.
        lat_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drive(32'hFFFFFFFD, 32'h5, 1'b1, 64'hFFFFFFFFFFFFFFF1, 1'b0);
            else if (i == 2) drive(32'h6, 32'h7, 1'b0, 64'd42, 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            hist[i] = out_valid;
            tick();
        end
        chk("bubble_pattern", {56'b0, hist}, 64'h28);

        // Reset mid-flight: three pairs in the pipe, one reset cycle, then idle.
        drive(32'd2, 32'd2, 1'b0, 64'd4, 1'b0);  tick();
        drive(32'd3, 32'd3, 1'b0, 64'd9, 1'b0);  tick();
        drive(32'd4, 32'd4, 1'b0, 64'd16, 1'b0); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        rst = 1'b0;
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_prod", Prod, 64'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || Prod != 64'd0) bad++;
            tick();
        end
        chk("midrst_idle", 64'(bad), 64'd0);
        base = n_out;
        drive(32'd7, 32'd9, 1'b0, 64'd63, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("midrst_new_count", 64'(n_out - base), 64'd1);

        chk("in_ready_rule", 64'(rdy_err), 64'd0);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
